// File: rtl/comparator_seq_pkg.sv
// Shared types and helpers for the sequential chunked comparator.
package comparator_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} cmp_state_t;

  // Index register width for a given chunk count; never narrower than one bit.
  function automatic int cmp_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/comparator_seq_if.sv
// Producer/consumer handshake bundle for comparator_seq.
interface comparator_seq_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         is_signed;
  logic         o_valid;
  logic         o_ready;
  logic         eq;
  logic         lt;
  logic         gt;

  modport master (
    output i_valid, a, b, is_signed, o_ready,
    input  i_ready, o_valid, eq, lt, gt
  );

  modport slave (
    input  i_valid, a, b, is_signed, o_ready,
    output i_ready, o_valid, eq, lt, gt
  );
endinterface

// File: rtl/comparator_seq_chunk.sv
// Combinational CHUNK-bit slice compare: equality, unsigned and signed less-than.
module comparator_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] ca,
  input  logic [CHUNK-1:0] cb,
  output logic             ch_eq,
  output logic             ch_lt_u,
  output logic             ch_lt_s
);
  logic signed [CHUNK-1:0] ca_s;
  logic signed [CHUNK-1:0] cb_s;

  assign ca_s    = ca;
  assign cb_s    = cb;
  assign ch_eq   = (ca == cb);
  assign ch_lt_u = (ca < cb);
  assign ch_lt_s = (ca_s < cb_s);
endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle magnitude/equality comparator, MSB chunk first.
// Define COMPARATOR_SEQ_EARLY_EXIT_EN to finish right after the first differing chunk.
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input logic             clk,
  input logic             rst_n,
  comparator_seq_if.slave bus
);
  localparam int NCHUNK = N / CHUNK;
  localparam int IDX_W  = cmp_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  cmp_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             lt_r;
  logic             gt_r;
  logic             res_vld;
  logic             res_eq;
  logic             res_lt;
  logic             res_gt;

  logic [N-1:0]     a_p0;
  logic [N-1:0]     b_p0;
  logic             sgn_p0;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             ch_eq;
  logic             ch_lt_u;
  logic             ch_lt_s;
  logic             hit;
  logic             hit_lt;
  logic             last;

  assign bus.i_ready = (state == S_IDLE);
  assign bus.o_valid = res_vld;
  assign bus.eq      = res_eq;
  assign bus.lt      = res_lt;
  assign bus.gt      = res_gt;

  // Operand capture on accept
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.i_valid) begin
      a_p0   <= bus.a;
      b_p0   <= bus.b;
      sgn_p0 <= bus.is_signed;
    end
  end

  assign ca = a_p0[idx*CHUNK +: CHUNK];
  assign cb = b_p0[idx*CHUNK +: CHUNK];

  comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
    .ca      (ca),
    .cb      (cb),
    .ch_eq   (ch_eq),
    .ch_lt_u (ch_lt_u),
    .ch_lt_s (ch_lt_s)
  );

  // Only the top chunk carries the sign; lower chunks are plain magnitude.
  assign hit    = !decided && !ch_eq;
  assign hit_lt = (idx == IDX_TOP && sgn_p0) ? ch_lt_s : ch_lt_u;

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  assign last = (idx == '0) || hit;
`else
  assign last = (idx == '0);
`endif

  // Chunk walk and result handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= IDX_TOP;
      decided <= 1'b0;
      lt_r    <= 1'b0;
      gt_r    <= 1'b0;
      res_vld <= 1'b0;
      res_eq  <= 1'b0;
      res_lt  <= 1'b0;
      res_gt  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_valid) begin
            state   <= S_BUSY;
            idx     <= IDX_TOP;
            decided <= 1'b0;
            lt_r    <= 1'b0;
            gt_r    <= 1'b0;
          end
        end
        S_BUSY: begin
          if (hit) begin
            decided <= 1'b1;
            lt_r    <= hit_lt;
            gt_r    <= !hit_lt;
          end
          if (last) begin
            state   <= S_DONE;
            res_vld <= 1'b1;
            res_eq  <= !(decided || hit);
            res_lt  <= hit ? hit_lt : lt_r;
            res_gt  <= hit ? !hit_lt : gt_r;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        S_DONE: begin
          if (bus.o_ready) begin
            state   <= S_IDLE;
            res_vld <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
- Multi-cycle, parametrised magnitude/equality comparator. Successor to the combinational equality comparator.
- Compares two N-bit operands CHUNK bits per cycle, MSB chunk first, and reports eq/lt/gt.
- Signed or unsigned mode is selected per operation.
- Sits between a producer and a consumer, with valid/ready handshakes on both sides; used where a full-width single-cycle compare would break timing.

Parameters:
- N, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NCHUNK = N/CHUNK, must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  producer has an operation.
- i_ready  output  1  block can accept; equals (state==S_IDLE).
- a  input  N  operand A; sampled on accept.
- b  input  N  operand B; sampled on accept.
- is_signed  input  1  1 = two's-complement compare; sampled on accept.
- o_valid  output  1  result available.
- o_ready  input  1  consumer takes the result.
- eq  output  1  a == b.
- lt  output  1  a < b in the selected mode.
- gt  output  1  a > b in the selected mode.

Behaviour:
- Reset:
  - rst_n low forces, asynchronously: state S_IDLE, o_valid=0, eq=0, lt=0, gt=0, chunk index=NCHUNK-1, decided flag=0.
  - i_valid is ignored while rst_n is low.
- S_IDLE:
  - On i_valid && i_ready (cycle T): register a, b, is_signed; set idx=NCHUNK-1, decided=0, lt_r=0, gt_r=0; go to S_BUSY.
- S_BUSY:
  - Each cycle, evaluate chunk idx = bits [idx*CHUNK+CHUNK-1 : idx*CHUNK].
  - If !decided and the two chunks differ: set decided=1.
  - When decided is set, the compare is signed if idx==NCHUNK-1 and is_signed; otherwise unsigned. Set lt_r/gt_r from that compare.
  - Chunks already decided are never re-evaluated.
  - When idx==0 has been processed: go to S_DONE. Otherwise idx decrements.
- S_DONE:
  - o_valid=1; eq=!decided, lt=lt_r, gt=gt_r.
  - Exactly one of eq/lt/gt is 1 whenever o_valid=1.
  - While o_valid && !o_ready, all outputs hold stable.
  - On o_valid && o_ready: return to S_IDLE; o_valid=0 next cycle.
  - eq/lt/gt keep their last values until the next result.
- Latency:
  - Accept at T, o_valid at T+NCHUNK+1.
  - Minimum issue interval is NCHUNK+2 cycles, because accept cannot overlap the output handshake.
- Boundaries:
  - NCHUNK==1: S_BUSY lasts one cycle, and the top-chunk signed rule applies.
  - i_valid held high during S_BUSY/S_DONE: no accept occurs; operands are not resampled.
  - Reset mid-S_BUSY or mid-S_DONE: operation is discarded; no o_valid pulse.

Optional Feature:
- Macro: COMPARATOR_SEQ_EARLY_EXIT_EN.
- Defined: S_BUSY goes to S_DONE in the cycle after the first differing chunk is evaluated. Latency is T+k+1, where k = number of chunks evaluated (1..NCHUNK). Equal operands still take NCHUNK cycles.
- Undefined: fixed latency of NCHUNK+1 regardless of data.

Decomposition:
- Package comparator_pkg:
  - typedef enum logic [1:0] cmp_state_t {S_IDLE, S_BUSY, S_DONE}.
  - Localparam helper for the index width, $clog2(NCHUNK) with minimum 1.
- Sub-module comparator_chunk:
  - Parametrised CHUNK-bit, structural/combinational.
  - Outputs: ch_eq, ch_lt_u, ch_lt_s.
  - One instance is muxed by idx.

Test Plan (N=32, CHUNK=8, accept at cycle T):
- a=b=32'hDEADBEEF, is_signed=0 -> eq=1 lt=0 gt=0; o_valid at T+5 in both builds.
- a=32'h00000001, b=32'h00000002, unsigned -> lt=1; o_valid at T+5 in both builds (difference in last chunk).
- a=32'hFFFFFFFF, b=32'h00000001 -> unsigned: gt=1. Signed: lt=1 (-1 < 1). With EARLY_EXIT_EN, o_valid at T+2.
- a=32'h80000000, b=32'h7FFFFFFF, signed -> lt=1. o_valid at T+2 with EARLY_EXIT_EN, T+5 without. Unsigned compare of the same operands -> gt=1.
- Backpressure: hold o_ready=0 for 3 cycles after o_valid, with i_valid=1 throughout. Expect o_valid/eq/lt/gt stable, i_ready=0 and no accept. Release o_ready: i_ready=1 the next cycle, and the next op is accepted.
- Pull rst_n low at T+2 during S_BUSY. Expect o_valid=0 and all outputs 0 immediately, and state S_IDLE. After release, a=5, b=5 gives eq=1 at the expected latency.
